// File: rtl/hazard_fwd_ctrl_if.sv
// Bundle of pipeline-side status inputs and latch-control outputs
// exchanged between the datapath and the hazard/forwarding controller.
interface hazard_fwd_ctrl_if #(
  parameter int REG_AW     = 5,
  parameter int NREAD      = 2,
  parameter int FWD_STAGES = 2,
  parameter int CNT_W      = 32
);
  localparam int SW = $clog2(FWD_STAGES + 1);

  // Status from the pipeline
  logic                         ihit;
  logic                         dhit;
  logic                         dmem_req;
  logic                         branch_flush;
  logic                         jump_flush;
  logic [NREAD*REG_AW-1:0]      id_rsel;
  logic [NREAD*REG_AW-1:0]      ex_rsel;
  logic                         ex_is_load;
  logic                         ex_regwr;
  logic [REG_AW-1:0]            ex_wsel;
  logic [FWD_STAGES-1:0]        stg_regwr;
  logic [FWD_STAGES*REG_AW-1:0] stg_wsel;
  logic                         perf_clr;

  // Controls back to the pipeline
  logic                         pc_wen;
  logic                         ifid_en;
  logic                         ifid_flush;
  logic                         idex_en;
  logic                         idex_flush;
  logic                         exmem_en;
  logic                         exmem_flush;
  logic                         memwb_en;
  logic [NREAD*SW-1:0]          fwd_sel;
  logic [CNT_W-1:0]             stall_cycles;

  // Pipeline side: drives status, consumes controls
  modport master (
    output ihit, dhit, dmem_req, branch_flush, jump_flush, id_rsel, ex_rsel,
           ex_is_load, ex_regwr, ex_wsel, stg_regwr, stg_wsel, perf_clr,
    input  pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, fwd_sel, stall_cycles
  );

  // Controller side: consumes status, drives controls
  modport slave (
    input  ihit, dhit, dmem_req, branch_flush, jump_flush, id_rsel, ex_rsel,
           ex_is_load, ex_regwr, ex_wsel, stg_regwr, stg_wsel, perf_clr,
    output pc_wen, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, fwd_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
// Forwarding selects and latch controls are combinational from the
// current state and inputs; only the load-use FSM, its bubble counter
// and the stall-cycle counter are registered.
module hazard_fwd_ctrl #(
  parameter int REG_AW         = 5,
  parameter int NREAD          = 2,
  parameter int FWD_STAGES     = 2,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int SW       = $clog2(FWD_STAGES + 1);
  localparam int BCW      = (LOAD_STALL_CYC > 2) ? $clog2(LOAD_STALL_CYC) : 1;
  localparam int LSC_INIT = (LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0;

  typedef enum logic {RUN, LSTALL} state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bub_q, bub_d;
  logic [CNT_W-1:0] stall_q;

  logic [NREAD-1:0]    id_match;
  logic [NREAD*SW-1:0] fwd_sel_c;
  logic                lu, memwait, flush, stall_inc;

  // Per-operand comparison of ID sources against the EX destination
  for (genvar gi = 0; gi < NREAD; gi++) begin : g_idm
    assign id_match[gi] = (bus.id_rsel[gi*REG_AW +: REG_AW] == bus.ex_wsel);
  end

  assign lu      = bus.ex_is_load && bus.ex_regwr && (bus.ex_wsel != '0) && (|id_match);
  assign memwait = bus.dmem_req && !bus.dhit;
  assign flush   = bus.branch_flush || bus.jump_flush;

  // Forwarding select: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_sel_c = '0;
    for (int r = 0; r < NREAD; r++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (bus.stg_regwr[k] && (bus.stg_wsel[k*REG_AW +: REG_AW] != '0) &&
            (bus.stg_wsel[k*REG_AW +: REG_AW] == bus.ex_rsel[r*REG_AW +: REG_AW])) begin
          fwd_sel_c[r*SW +: SW] = SW'(k + 1);
        end
      end
    end
  end

  assign bus.fwd_sel      = fwd_sel_c;
  assign bus.stall_cycles = stall_q;

  // Latch controls and FSM next state; a memory wait freezes everything
  always_comb begin
    bus.pc_wen      = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_en     = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.memwb_en    = 1'b0;
    state_d         = state_q;
    bub_d           = bub_q;
    stall_inc       = memwait;
    if (!memwait) begin
      bus.exmem_en    = bus.ihit || bus.dhit;
      bus.memwb_en    = bus.ihit || bus.dhit;
      bus.exmem_flush = bus.dhit;
      if (flush) begin
        // Taken control transfer squashes IF/ID and ID/EX and cancels any stall
        bus.pc_wen     = bus.ihit;
        bus.ifid_en    = bus.ihit;
        bus.ifid_flush = 1'b1;
        bus.idex_en    = bus.ihit;
        bus.idex_flush = 1'b1;
        state_d        = RUN;
      end else if (state_q == LSTALL) begin
        bus.idex_en    = bus.ihit;
        bus.idex_flush = 1'b1;
        stall_inc      = 1'b1;
        if (bus.ihit) begin
          if (bub_q == '0) state_d = RUN;
          else             bub_d   = bub_q - BCW'(1);
        end
      end else if (lu) begin
        // First bubble is issued from RUN; extra bubbles come from LSTALL
        bus.idex_en    = bus.ihit;
        bus.idex_flush = 1'b1;
        stall_inc      = 1'b1;
        if (bus.ihit && (LOAD_STALL_CYC > 1)) begin
          state_d = LSTALL;
          bub_d   = BCW'(LSC_INIT);
        end
      end else begin
        bus.pc_wen  = bus.ihit;
        bus.ifid_en = bus.ihit;
        bus.idex_en = bus.ihit;
      end
    end
  end

  // Load-use FSM state and remaining-bubble counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Saturating stall-cycle counter; clear beats increment
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
    end else if (bus.perf_clr) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end
endmodule
